// File: rtl/xif_mac_coproc_if.sv
// eXtension-interface channels between the core (master) and the MAC coprocessor (slave).
// Signal names follow the core-side X_EXT port list so the wiring reads one-to-one.
interface xif_mac_coproc_if #(
  parameter int X_ID_WIDTH = 4
);
  logic                  issue_valid_i;
  logic                  issue_ready_o;
  logic [31:0]           issue_instr_i;
  logic [X_ID_WIDTH-1:0] issue_id_i;
  logic [31:0]           issue_rs0_i;
  logic [31:0]           issue_rs1_i;
  logic [1:0]            issue_rs_valid_i;
  logic                  issue_accept_o;
  logic                  issue_writeback_o;

  logic                  commit_valid_i;
  logic [X_ID_WIDTH-1:0] commit_id_i;
  logic                  commit_kill_i;

  logic                  result_valid_o;
  logic                  result_ready_i;
  logic [X_ID_WIDTH-1:0] result_id_o;
  logic [31:0]           result_data_o;
  logic [4:0]            result_rd_o;
  logic                  result_we_o;

  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i, issue_rs0_i, issue_rs1_i, issue_rs_valid_i,
    output commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o,
    input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
  );

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs0_i, issue_rs1_i, issue_rs_valid_i,
    input  commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o,
    output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
  );
endinterface

// File: rtl/xif_mac_coproc.sv
// Single-issue X-interface coprocessor: custom-0 MAC / CLR / RDACC on a 32-bit accumulator,
// with a radix-2^BITS_PER_CYCLE sequential shift-add multiplier.
module xif_mac_coproc #(
  parameter int          X_ID_WIDTH     = 4,
  parameter int          BITS_PER_CYCLE = 1,
  parameter logic [6:0]  OPCODE         = 7'h0B
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  xif_mac_coproc_if.slave    xif,
  output logic               busy_o,
  output logic [31:0]        acc_o
);

  typedef enum logic [1:0] {IDLE, WAIT_COMMIT, EXEC, RESULT} state_t;

  localparam int         N_STEPS   = 32 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST_STEP = 5'(N_STEPS - 1);
  localparam logic [2:0] F3_MAC    = 3'b000;
  localparam logic [2:0] F3_CLR    = 3'b001;
  localparam logic [2:0] F3_RDACC  = 3'b010;

  state_t                state_q, state_d;
  logic [X_ID_WIDTH-1:0] id_q;
  logic [4:0]            rd_q;
  logic [2:0]            f3_q;
  logic [31:0]           mcand_q, mplier_q, prod_q, partial, prod_next;
  logic [4:0]            cnt_q;
  logic [31:0]           acc_q, res_data_q;

  logic [2:0] issue_f3;
  logic       match, operands_ok, issue_fire, issue_commit, wait_commit;
  logic       ctl_start;
  logic [2:0] cur_f3;
  logic       unused_instr;

  // Decode is purely combinational and ignores state; only the handshake depends on IDLE.
  assign issue_f3    = xif.issue_instr_i[14:12];
  assign match       = (xif.issue_instr_i[6:0] == OPCODE) &&
                       (issue_f3 == F3_MAC || issue_f3 == F3_CLR || issue_f3 == F3_RDACC);
  assign operands_ok = (issue_f3 != F3_MAC) || (xif.issue_rs_valid_i == 2'b11);
  assign unused_instr = ^xif.issue_instr_i[31:15];

  assign xif.issue_accept_o    = xif.issue_valid_i & match & operands_ok;
  assign xif.issue_writeback_o = xif.issue_accept_o;
  assign xif.issue_ready_o     = (state_q == IDLE);

  assign issue_fire   = xif.issue_accept_o & (state_q == IDLE);
  assign issue_commit = xif.commit_valid_i & (xif.commit_id_i == xif.issue_id_i);
  assign wait_commit  = xif.commit_valid_i & (xif.commit_id_i == id_q);
  assign cur_f3       = (state_q == IDLE) ? issue_f3 : f3_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (issue_fire) begin
          if (!issue_commit)             state_d = WAIT_COMMIT;
          else if (!xif.commit_kill_i)   state_d = (issue_f3 == F3_MAC) ? EXEC : RESULT;
        end
      end
      WAIT_COMMIT: begin
        if (wait_commit)
          state_d = xif.commit_kill_i ? IDLE : ((f3_q == F3_MAC) ? EXEC : RESULT);
      end
      EXEC:    if (cnt_q == LAST_STEP)     state_d = RESULT;
      RESULT:  if (xif.result_ready_i)     state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // CLR/RDACC snapshot the accumulator on the way into RESULT.
  assign ctl_start = (state_d == RESULT) && (state_q == IDLE || state_q == WAIT_COMMIT);

  always_comb begin
    partial = '0;
    for (int b = 0; b < BITS_PER_CYCLE; b++)
      if (mplier_q[b]) partial = partial + (mcand_q << b);
  end
  assign prod_next = prod_q + partial;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: these are plain flops, not a memory, so all of them are reset to keep outputs defined.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q       <= '0;
      rd_q       <= '0;
      f3_q       <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      res_data_q <= '0;
    end else begin
      if (issue_fire) begin
        id_q     <= xif.issue_id_i;
        rd_q     <= xif.issue_instr_i[11:7];
        f3_q     <= issue_f3;
        mcand_q  <= xif.issue_rs0_i;
        mplier_q <= xif.issue_rs1_i;
        prod_q   <= '0;
        cnt_q    <= '0;
      end
      if (state_q == EXEC) begin
        mcand_q  <= mcand_q << BITS_PER_CYCLE;
        mplier_q <= mplier_q >> BITS_PER_CYCLE;
        prod_q   <= prod_next;
        cnt_q    <= cnt_q + 5'd1;
        if (cnt_q == LAST_STEP) begin
          acc_q      <= acc_q + prod_next;
          res_data_q <= acc_q + prod_next;
        end
      end
      if (ctl_start) begin
        res_data_q <= acc_q;
        if (cur_f3 == F3_CLR) acc_q <= '0;
      end
    end
  end

  assign xif.result_valid_o = (state_q == RESULT);
  assign xif.result_we_o    = xif.result_valid_o;
  assign xif.result_id_o    = xif.result_valid_o ? id_q       : '0;
  assign xif.result_rd_o    = xif.result_valid_o ? rd_q       : '0;
  assign xif.result_data_o  = xif.result_valid_o ? res_data_q : '0;

  assign busy_o = (state_q != IDLE);
  assign acc_o  = acc_q;

endmodule

// File: tb/tb_xif_mac_coproc.sv
// Self-checking bench for xif_mac_coproc: decode table, transaction table with a result
// scoreboard, plus hand-written latency, backpressure and mid-EXEC reset sequences.
module tb_xif_mac_coproc;

  localparam int XW       = 4;
  localparam int BPC      = 1;
  localparam int EXEC_LAT = 32 / BPC;

  logic        clk_i  = 1'b0;
  logic        rst_ni = 1'b0;
  logic        busy_o;
  logic [31:0] acc_o;

  always #5 clk_i = ~clk_i;

  xif_mac_coproc_if #(.X_ID_WIDTH(XW)) xif ();

  xif_mac_coproc #(
    .X_ID_WIDTH(XW), .BITS_PER_CYCLE(BPC), .OPCODE(7'h0B)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .xif(xif), .busy_o(busy_o), .acc_o(acc_o)
  );

  typedef struct {
    logic [XW-1:0] id;
    logic [4:0]    rd;
    logic [31:0]   data;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  rsv;
    bit          accept;
  } dec_t;

  typedef struct {
    logic [2:0]    f3;
    logic [4:0]    rd;
    logic [XW-1:0] id;
    logic [31:0]   rs0;
    logic [31:0]   rs1;
    bit            kill;
    bit            same;
    bit            stray;
  } txn_t;

  exp_t        sb[$];
  int          errors    = 0;
  int          checks    = 0;
  int          n_results = 0;
  logic [31:0] exp_acc   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic [4:0] rd);
    return {17'h0, f3, rd, opc};
  endfunction

  // Result monitor: every transfer must match the oldest expected entry.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (rst_ni && xif.result_valid_o && xif.result_ready_i) begin
      n_results++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got id %0d data 0x%08h expected no result",
                 xif.result_id_o, xif.result_data_o);
      end else begin
        e = sb.pop_front();
        check("result_data", xif.result_data_o, e.data);
        check("result_id",   32'(xif.result_id_o), 32'(e.id));
        check("result_rd",   32'(xif.result_rd_o), 32'(e.rd));
        check("result_we",   32'(xif.result_we_o), 32'd1);
      end
    end
  end

  // Reference model update for a committed instruction; returns the expected rd data.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] d;
    logic [31:0] p;
    d = exp_acc;
    if (f3 == 3'b000) begin
      p       = a * b;
      exp_acc = exp_acc + p;
      d       = exp_acc;
    end else if (f3 == 3'b001) begin
      exp_acc = '0;
    end
    return d;
  endfunction

  task automatic drive_issue(input logic [31:0] instr, input logic [XW-1:0] id,
                             input logic [31:0] a, input logic [31:0] b, input logic [1:0] rsv);
    xif.issue_valid_i    = 1'b1;
    xif.issue_instr_i    = instr;
    xif.issue_id_i       = id;
    xif.issue_rs0_i      = a;
    xif.issue_rs1_i      = b;
    xif.issue_rs_valid_i = rsv;
  endtask

  task automatic wait_idle(input string name);
    int budget;
    budget = 0;
    while (busy_o && budget < 200) begin
      @(posedge clk_i); #1;
      budget++;
    end
    check(name, 32'(busy_o), 32'd0);
  endtask

  task automatic run_txn(input txn_t t);
    exp_t e;
    @(posedge clk_i); #1;
    check("txn_issue_ready", 32'(xif.issue_ready_o), 32'd1);
    drive_issue(mk_instr(7'h0B, t.f3, t.rd), t.id, t.rs0, t.rs1, 2'b11);
    if (t.same) begin
      xif.commit_valid_i = 1'b1;
      xif.commit_id_i    = t.id;
      xif.commit_kill_i  = t.kill;
    end
    #1 check("txn_accept", 32'(xif.issue_accept_o), 32'd1);
    @(posedge clk_i); #1;
    xif.issue_valid_i  = 1'b0;
    xif.commit_valid_i = 1'b0;
    if (!t.same) begin
      if (t.stray) begin
        xif.commit_valid_i = 1'b1;
        xif.commit_id_i    = t.id ^ XW'(1);
        xif.commit_kill_i  = 1'b1;
        @(posedge clk_i); #1;
        xif.commit_valid_i = 1'b0;
        check("stray_commit_ignored", 32'(busy_o), 32'd1);
      end
      xif.commit_valid_i = 1'b1;
      xif.commit_id_i    = t.id;
      xif.commit_kill_i  = t.kill;
      @(posedge clk_i); #1;
      xif.commit_valid_i = 1'b0;
    end
    xif.commit_kill_i = 1'b0;
    if (t.kill) begin
      check("kill_ready_next", 32'(xif.issue_ready_o), 32'd1);
      check("kill_not_busy",   32'(busy_o), 32'd0);
    end else begin
      e.id   = t.id;
      e.rd   = t.rd;
      e.data = model(t.f3, t.rs0, t.rs1);
      sb.push_back(e);
    end
    wait_idle("txn_done");
    check("txn_acc", acc_o, exp_acc);
  endtask

  dec_t dec[8];
  txn_t txns[12];

  initial begin : main
    exp_t        e;
    int          lat;
    int          saved;
    logic [31:0] bp_data;

    dec[0] = '{mk_instr(7'h0B, 3'b000, 5'd1), 2'b11, 1'b1};
    dec[1] = '{mk_instr(7'h0B, 3'b000, 5'd1), 2'b01, 1'b0};
    dec[2] = '{mk_instr(7'h0B, 3'b000, 5'd1), 2'b00, 1'b0};
    dec[3] = '{mk_instr(7'h0B, 3'b001, 5'd1), 2'b00, 1'b1};
    dec[4] = '{mk_instr(7'h0B, 3'b010, 5'd1), 2'b10, 1'b1};
    dec[5] = '{mk_instr(7'h0B, 3'b011, 5'd1), 2'b11, 1'b0};
    dec[6] = '{mk_instr(7'h33, 3'b000, 5'd1), 2'b11, 1'b0};
    dec[7] = '{mk_instr(7'h0B, 3'b111, 5'd1), 2'b11, 1'b0};

    //                 f3      rd     id     rs0           rs1           kill same stray
    txns[0]  = '{3'b010, 5'd5,  4'd3,  32'd0,        32'd0,        0, 0, 0};
    txns[1]  = '{3'b000, 5'd11, 4'd4,  32'd7,        32'd9,        0, 1, 0};
    txns[2]  = '{3'b000, 5'd12, 4'd1,  32'd2,        32'd2,        1, 0, 0};
    txns[3]  = '{3'b001, 5'd1,  4'd6,  32'd0,        32'd0,        0, 1, 0};
    txns[4]  = '{3'b000, 5'd2,  4'd7,  32'hFFFFFFF0, 32'd1,        0, 0, 1};
    txns[5]  = '{3'b000, 5'd3,  4'd8,  32'h10,       32'h2,        0, 0, 0};
    txns[6]  = '{3'b000, 5'd4,  4'd9,  32'h12345678, 32'h9ABCDEF1, 0, 0, 0};
    txns[7]  = '{3'b001, 5'd13, 4'd10, 32'd0,        32'd0,        1, 1, 0};
    txns[8]  = '{3'b001, 5'd6,  4'd11, 32'd0,        32'd0,        0, 0, 0};
    txns[9]  = '{3'b000, 5'd7,  4'd12, 32'd7,        32'd1,        0, 0, 0};
    txns[10] = '{3'b001, 5'd8,  4'd13, 32'd0,        32'd0,        0, 0, 0};
    txns[11] = '{3'b010, 5'd9,  4'd14, 32'd0,        32'd0,        0, 1, 0};

    xif.issue_valid_i    = 1'b0;
    xif.issue_instr_i    = '0;
    xif.issue_id_i       = '0;
    xif.issue_rs0_i      = '0;
    xif.issue_rs1_i      = '0;
    xif.issue_rs_valid_i = '0;
    xif.commit_valid_i   = 1'b0;
    xif.commit_id_i      = '0;
    xif.commit_kill_i    = 1'b0;
    xif.result_ready_i   = 1'b1;

    #12;
    check("rst_issue_ready",  32'(xif.issue_ready_o),  32'd1);
    check("rst_busy",         32'(busy_o),             32'd0);
    check("rst_acc",          acc_o,                   32'd0);
    check("rst_result_valid", 32'(xif.result_valid_o), 32'd0);
    check("rst_result_data",  xif.result_data_o,       32'd0);
    check("rst_accept",       32'(xif.issue_accept_o), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Decode / rejection table.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      drive_issue(dec[i].instr, '0, 32'd1, 32'd1, dec[i].rsv);
      #1;
      check("dec_accept",    32'(xif.issue_accept_o),    32'(dec[i].accept));
      check("dec_writeback", 32'(xif.issue_writeback_o), 32'(dec[i].accept));
      if (!dec[i].accept) @(posedge clk_i);
      #1;
      xif.issue_valid_i = 1'b0;
      check("dec_busy",  32'(busy_o),            32'd0);
      check("dec_ready", 32'(xif.issue_ready_o), 32'd1);
    end

    // MAC basic with exact latency from the commit cycle.
    @(posedge clk_i); #1;
    drive_issue(mk_instr(7'h0B, 3'b000, 5'd10), 4'd2, 32'd3, 32'd5, 2'b11);
    @(posedge clk_i); #1;
    xif.issue_valid_i  = 1'b0;
    xif.commit_valid_i = 1'b1;
    xif.commit_id_i    = 4'd2;
    xif.commit_kill_i  = 1'b0;
    e.id   = 4'd2;
    e.rd   = 5'd10;
    e.data = model(3'b000, 32'd3, 32'd5);
    sb.push_back(e);
    lat = 0;
    do begin
      @(posedge clk_i); #1;
      xif.commit_valid_i = 1'b0;
      lat++;
    end while (!xif.result_valid_o && lat < 100);
    check("mac_latency", 32'(lat), 32'(EXEC_LAT + 1));
    wait_idle("mac_basic_done");
    check("mac_basic_acc", acc_o, 32'd15);

    for (int i = 0; i < 12; i++) run_txn(txns[i]);

    // Backpressure on an RDACC result.
    @(posedge clk_i); #1;
    xif.result_ready_i = 1'b0;
    drive_issue(mk_instr(7'h0B, 3'b010, 5'd21), 4'd15, 32'd0, 32'd0, 2'b00);
    xif.commit_valid_i = 1'b1;
    xif.commit_id_i    = 4'd15;
    @(posedge clk_i); #1;
    xif.issue_valid_i  = 1'b0;
    xif.commit_valid_i = 1'b0;
    bp_data = model(3'b010, 32'd0, 32'd0);
    saved = n_results;
    for (int c = 0; c < 10; c++) begin
      check("bp_valid", 32'(xif.result_valid_o), 32'd1);
      check("bp_data",  xif.result_data_o,       bp_data);
      check("bp_id",    32'(xif.result_id_o),    32'd15);
      check("bp_rd",    32'(xif.result_rd_o),    32'd21);
      check("bp_ready", 32'(xif.issue_ready_o),  32'd0);
      @(posedge clk_i); #1;
    end
    e.id   = 4'd15;
    e.rd   = 5'd21;
    e.data = bp_data;
    sb.push_back(e);
    xif.result_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("bp_released_valid", 32'(xif.result_valid_o), 32'd0);
    check("bp_released_ready", 32'(xif.issue_ready_o),  32'd1);
    check("bp_single_transfer", 32'(n_results - saved), 32'd1);

    // Asynchronous reset in the middle of EXEC.
    @(posedge clk_i); #1;
    drive_issue(mk_instr(7'h0B, 3'b000, 5'd22), 4'd5, 32'd100, 32'd100, 2'b11);
    xif.commit_valid_i = 1'b1;
    xif.commit_id_i    = 4'd5;
    @(posedge clk_i); #1;
    xif.issue_valid_i  = 1'b0;
    xif.commit_valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    check("pre_reset_busy", 32'(busy_o), 32'd1);
    saved = n_results;
    #2 rst_ni = 1'b0;
    #1;
    exp_acc = '0;
    check("mid_rst_ready", 32'(xif.issue_ready_o),  32'd1);
    check("mid_rst_busy",  32'(busy_o),             32'd0);
    check("mid_rst_acc",   acc_o,                   32'd0);
    check("mid_rst_valid", 32'(xif.result_valid_o), 32'd0);
    check("mid_rst_data",  xif.result_data_o,       32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (EXEC_LAT + 8) @(posedge clk_i);
    #1;
    check("post_rst_no_result", 32'(n_results - saved), 32'd0);
    check("post_rst_acc",       acc_o,                   exp_acc);
    check("sb_empty",           32'(sb.size()),          32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/xif_mac_coproc.md
Name: xif_mac_coproc

Overview:
- Single-issue eXtension-interface coprocessor attached to the cv32e40x core's X_EXT port; connects to the same issue, commit and result channels the core drives.
- Executes custom-0 multiply-accumulate instructions using a sequential shift-add multiplier and a 32-bit architectural accumulator.
- Returns register writeback data to the core through the result channel.
- Compressed, mem and mem_result channels are tied off outside this block.

Parameters:
X_ID_WIDTH, 4, width of instruction id fields
BITS_PER_CYCLE, 1, multiplier bits retired per EXEC cycle; legal values 1, 2, 4, 8; 32/BITS_PER_CYCLE = EXEC latency
OPCODE, 7'h0B, custom-0 major opcode decoded in instr[6:0]

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
issue_valid_i  in  1  core offers instruction
issue_ready_o  out  1  coprocessor can take instruction
issue_instr_i  in  32  instruction word
issue_id_i  in  X_ID_WIDTH  instruction id
issue_rs0_i  in  32  rs1 value
issue_rs1_i  in  32  rs2 value
issue_rs_valid_i  in  2  operand valid flags
issue_accept_o  out  1  instruction is ours (combinational, valid with issue_valid_i)
issue_writeback_o  out  1  instruction writes rd (equals issue_accept_o)
commit_valid_i  in  1  commit strobe
commit_id_i  in  X_ID_WIDTH  committed id
commit_kill_i  in  1  discard instruction
result_valid_o  out  1  result available
result_ready_i  in  1  core takes result
result_id_o  out  X_ID_WIDTH  id of result
result_data_o  out  32  rd writeback data
result_rd_o  out  5  destination register
result_we_o  out  1  write enable (always 1 when result_valid_o)
busy_o  out  1  state != IDLE
acc_o  out  32  current accumulator (debug)

Behaviour:
- Reset values: state IDLE; acc 0; all outputs 0 except issue_ready_o=1.
- Decode: match = instr[6:0]==OPCODE and funct3 in {000 MAC, 001 CLR, 010 RDACC}.
- Operand readiness: MAC additionally requires issue_rs_valid_i==2'b11. CLR and RDACC ignore rs_valid.
- issue_accept_o = issue_valid_i & match & operand readiness. Combinational, independent of state.
- Issue handshake: issue_valid_i & issue_ready_o. issue_ready_o=1 only in IDLE.
- Non-accepted handshake: no state change.
- On an accepted handshake, latch id, rd=instr[11:7], funct3, rs0, rs1, then go to WAIT_COMMIT.
- Same-cycle commit: a commit_valid_i with commit_id_i==issue_id_i in the issue-handshake cycle is honored. On kill, stay IDLE. Otherwise go directly to EXEC (MAC) or RESULT (CLR/RDACC).
- WAIT_COMMIT: only commit_valid_i with commit_id_i==latched id is observed; non-matching ids are ignored.
  - kill=1: go to IDLE with no side effects.
  - kill=0: go to EXEC for MAC, RESULT for CLR/RDACC.
- EXEC:
  - Radix-2^BITS_PER_CYCLE shift-add of rs0*rs1, low 32 bits only (unsigned; identical to signed low word).
  - Counter runs 0..32/BITS_PER_CYCLE-1.
  - On the last cycle, acc <= acc + product (mod 2^32), then go to RESULT.
  - EXEC latency is exactly 32/BITS_PER_CYCLE cycles.
- RESULT:
  - result_valid_o=1.
  - result_data_o by funct3: MAC returns the new acc; CLR returns the pre-clear acc; RDACC returns acc.
  - For CLR, acc <= 0 on entry to RESULT.
  - All result fields stay stable while result_valid_o=1 and result_ready_i=0.
  - On result_valid_o & result_ready_i, go to IDLE; issue_ready_o is 1 in the next cycle.
- acc changes only on MAC completion or CLR commit; a killed instruction never alters acc.
- Asynchronous reset mid-operation aborts everything: no result is emitted and acc returns to 0.
- Commit strobes arriving in EXEC or RESULT are ignored.

Test Plan:
- MAC basic: acc=0; issue MAC rs1=3, rs2=5, rd=x10, id=2; commit id 2 kill=0 -> with BITS_PER_CYCLE=1, result_valid_o rises 33 cycles after the commit cycle (32 EXEC cycles + 1 RESULT); data=15, rd=10, id=2; acc_o=15.
- Accumulate and wrap: acc=0xFFFFFFF0; MAC rs1=0x10, rs2=0x2 -> result 0x00000010, acc wraps modulo 2^32.
- Kill: issue MAC id=1, then commit id=1 kill=1 -> no result_valid_o; acc unchanged; issue_ready_o=1 the cycle after the kill.
- Backpressure: RDACC with result_ready_i held 0 for 10 cycles -> result_valid_o and all result fields stable; issue_ready_o stays 0; a single transfer occurs when ready rises.
- Rejection: opcode 0x33, or MAC with rs_valid=2'b01 -> issue_accept_o=0; state stays IDLE; busy_o=0.
- CLR plus async reset: acc=7; CLR -> result data=7, then acc_o=0. Then issue a MAC, assert rst_ni low mid-EXEC -> all outputs at reset values; acc_o=0; no result emitted.
